// File: rtl/radix4_booth_digit_source.sv
// Streams the radix-4 Booth recoding of a signed operand, one digit per handshake.
// Digit outputs are registered; a new operand can be taken while the last digit leaves.
module radix4_booth_digit_source #(
    parameter int WIDTH     = 8,
    parameter bit MSD_FIRST = 1'b0,
    localparam int NDIG     = WIDTH / 2,
    localparam int IDXW     = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [2:0]       q_digit,
    output logic [IDXW-1:0]  q_index,
    output logic             q_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] FIRST_IDX = MSD_FIRST ? IDXW'(NDIG - 1) : '0;
    localparam logic [IDXW-1:0] LAST_IDX  = MSD_FIRST ? '0 : IDXW'(NDIG - 1);

    // Booth triple {b[2i+1], b[2i], b[2i-1]} to a 3-bit two's-complement digit.
    function automatic logic [2:0] booth_digit(input logic [2:0] triple);
        logic [2:0] d;
        case (triple)
            3'b000:  d = 3'b000;
            3'b001:  d = 3'b001;
            3'b010:  d = 3'b001;
            3'b011:  d = 3'b010;
            3'b100:  d = 3'b110;
            3'b101:  d = 3'b111;
            3'b110:  d = 3'b111;
            default: d = 3'b000;
        endcase
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH:0]   opnd_q, opnd_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [2:0]       digit_q, digit_d;
    logic             last_q, last_d;
    logic             ready_c;

    // Bit 0 of the operand register is the implicit b[-1] = 0.
    logic [WIDTH:0]   load_opnd;
    logic [2:0]       cur_dig [NDIG];
    logic [2:0]       new_dig [NDIG];

    assign load_opnd = {in_value, 1'b0};

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_recode
            assign cur_dig[gi] = booth_digit(opnd_q[2*gi +: 3]);
            assign new_dig[gi] = booth_digit(load_opnd[2*gi +: 3]);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        last_d  = last_q;
        ready_c = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    state_d = EMIT;
                    opnd_d  = load_opnd;
                    idx_d   = FIRST_IDX;
                    digit_d = new_dig[FIRST_IDX];
                    last_d  = 1'b0;
                end
            end
            EMIT: begin
                if (q_ready) begin
                    if (last_q) begin
                        ready_c = 1'b1;
                        if (in_valid) begin
                            state_d = EMIT;
                            opnd_d  = load_opnd;
                            idx_d   = FIRST_IDX;
                            digit_d = new_dig[FIRST_IDX];
                            last_d  = 1'b0;
                        end else begin
                            // Outputs read as zero whenever nothing is valid.
                            state_d = IDLE;
                            idx_d   = '0;
                            digit_d = 3'b000;
                            last_d  = 1'b0;
                        end
                    end else begin
                        idx_d   = MSD_FIRST ? (idx_q - 1'b1) : (idx_q + 1'b1);
                        digit_d = cur_dig[idx_d];
                        last_d  = (idx_d == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            idx_q   <= '0;
            digit_q <= 3'b000;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            last_q  <= last_d;
        end
    end

    assign in_ready = rst_n & ready_c;
    assign q_valid  = (state_q == EMIT);
    assign q_digit  = digit_q;
    assign q_index  = idx_q;
    assign q_last   = last_q;

endmodule

// File: tb/tb_radix4_booth_digit_source.sv
// Drives an LSB-first and an MSB-first instance in lockstep and checks both
// against a digit-list reference model, a known-answer table and digit sums.
module tb_radix4_booth_digit_source;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_value;
    logic       q_ready;
    logic       in_ready0, q_valid0, q_last0;
    logic [2:0] q_digit0;
    logic [1:0] q_index0;
    logic       in_ready1, q_valid1, q_last1;
    logic [2:0] q_digit1;
    logic [1:0] q_index1;

    always #5 clk = ~clk;

    radix4_booth_digit_source #(.WIDTH(8), .MSD_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_value(in_value), .q_valid(q_valid0), .q_ready(q_ready),
        .q_digit(q_digit0), .q_index(q_index0), .q_last(q_last0)
    );

    radix4_booth_digit_source #(.WIDTH(8), .MSD_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_value(in_value), .q_valid(q_valid1), .q_ready(q_ready),
        .q_digit(q_digit1), .q_index(q_index1), .q_last(q_last1)
    );

    typedef struct {
        int d0;
        int i0;
        int d1;
        int i1;
        bit last;
    } exp_t;

    typedef struct packed {
        logic [7:0]        val;
        logic signed [2:0] d0;
        logic signed [2:0] d1;
        logic signed [2:0] d2;
        logic signed [2:0] d3;
    } vec_t;

    exp_t exp_q[$];
    int   opnd_q[$];
    int   cap0[$];
    int   cap1[$];
    int   sum0, sum1;
    int   checks = 0;
    int   errors = 0;
    bit   rand_mode = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: d[i] = -2*b[2i+1] + b[2i] + b[2i-1] with b[-1] = 0.
    function automatic int ref_digit(input int v, input int i);
        int b2, b1, b0;
        b2 = (v >>> (2*i + 1)) & 1;
        b1 = (v >>> (2*i)) & 1;
        b0 = (i == 0) ? 0 : ((v >>> (2*i - 1)) & 1);
        return -2*b2 + b1 + b0;
    endfunction

    function automatic int vec_digit(input vec_t v, input int i);
        case (i)
            0:       return int'(v.d0);
            1:       return int'(v.d1);
            2:       return int'(v.d2);
            default: return int'(v.d3);
        endcase
    endfunction

    task automatic chk_out(input string tag, input logic v, input logic [2:0] dg,
                           input logic [1:0] ix, input logic lst,
                           input bit ev, input int ed, input int ei, input bit el);
        int dv;
        dv = $signed(dg);
        chk({tag, "_valid"}, int'(v), int'(ev));
        if (!ev) begin
            chk({tag, "_idle_zero"}, int'({dg, ix, lst}), 0);
        end else begin
            chk({tag, "_digit"}, dv, ed);
            chk({tag, "_index"}, int'(ix), ei);
            chk({tag, "_last"}, int'(lst), int'(el));
            chk({tag, "_legal_code"}, int'(dg == 3'b011 || dg == 3'b100 || dg == 3'b101), 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready_lsb", int'(in_ready0), 0);
            chk("rst_in_ready_msb", int'(in_ready1), 0);
            exp_q.delete();
            opnd_q.delete();
            cap0.delete();
            cap1.delete();
            sum0 = 0;
            sum1 = 0;
        end else begin
            bit   ev;
            bit   er;
            exp_t e;
            ev = (exp_q.size() > 0);
            er = (exp_q.size() == 0) || (exp_q.size() == 1 && q_ready);
            e  = '{0, 0, 0, 0, 1'b0};
            if (ev) e = exp_q[0];
            chk("in_ready_lsb", int'(in_ready0), int'(er));
            chk("in_ready_msb", int'(in_ready1), int'(er));
            chk_out("lsb", q_valid0, q_digit0, q_index0, q_last0, ev, e.d0, e.i0, e.last);
            chk_out("msb", q_valid1, q_digit1, q_index1, q_last1, ev, e.d1, e.i1, e.last);
            if (ev && q_ready) begin
                int dv0, dv1;
                dv0 = $signed(q_digit0);
                dv1 = $signed(q_digit1);
                cap0.push_back(dv0);
                cap1.push_back(dv1);
                sum0 += dv0 * (1 << (2 * int'(q_index0)));
                sum1 += dv1 * (1 << (2 * int'(q_index1)));
                void'(exp_q.pop_front());
                if (e.last) begin
                    chk("sum_lsb", sum0, opnd_q[0]);
                    chk("sum_msb", sum1, opnd_q[0]);
                    void'(opnd_q.pop_front());
                    sum0 = 0;
                    sum1 = 0;
                end
            end
            if (in_valid && in_ready0) begin
                int v;
                v = int'($signed(in_value));
                opnd_q.push_back(v);
                for (int i = 0; i < 4; i++) begin
                    exp_q.push_back('{ref_digit(v, i), i, ref_digit(v, 3 - i), 3 - i, (i == 3)});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) q_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present an operand until accepted, then scramble in_value to prove capture.
    task automatic send(input logic [7:0] v);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_value = v;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (in_ready0) done = 1'b1;
        end
        if (!done) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = 8'($urandom);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(posedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_caps(input vec_t v);
        chk("cap_count_lsb", cap0.size(), 4);
        chk("cap_count_msb", cap1.size(), 4);
        for (int i = 0; i < 4 && i < cap0.size() && i < cap1.size(); i++) begin
            chk($sformatf("tbl_%0d_lsb_d%0d", $signed(v.val), i), cap0[i], vec_digit(v, i));
            chk($sformatf("tbl_%0d_msb_d%0d", $signed(v.val), 3 - i), cap1[i], vec_digit(v, 3 - i));
        end
        $display("operand %0d digits lsb-first %p msb-first %p", $signed(v.val), cap0, cap1);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{val: 8'd91,   d0: -3'sd1, d1: -3'sd1, d2: 3'sd2, d3: 3'sd1};
        tbl[1] = '{val: 8'h80,   d0: 3'sd0,  d1: 3'sd0,  d2: 3'sd0, d3: -3'sd2};
        tbl[2] = '{val: 8'd127,  d0: -3'sd1, d1: 3'sd0,  d2: 3'sd0, d3: 3'sd2};
        tbl[3] = '{val: 8'hFF,   d0: -3'sd1, d1: 3'sd0,  d2: 3'sd0, d3: 3'sd0};
        tbl[4] = '{val: 8'd5,    d0: 3'sd1,  d1: 3'sd1,  d2: 3'sd0, d3: 3'sd0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = 8'd0;
        q_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q_valid", int'(q_valid0 | q_valid1), 0);
        chk("reset_outputs", int'({q_digit0, q_index0, q_last0, q_digit1, q_index1, q_last1}), 0);
        chk("reset_in_ready", int'(in_ready0 | in_ready1), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", int'(in_ready0 & in_ready1), 1);

        // Known-answer table with the consumer always ready.
        q_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cap0.delete();
            cap1.delete();
            send(tbl[k].val);
            drain();
            check_caps(tbl[k]);
        end

        // Stall on index 1 for three cycles.
        cap0.delete();
        cap1.delete();
        q_ready = 1'b0;
        send(8'd91);
        q_ready = 1'b1;
        @(posedge clk);
        #1;
        q_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_digit", int'($signed(q_digit0)), -1);
            chk("stall_index", int'(q_index0), 1);
        end
        @(posedge clk);
        #1;
        q_ready = 1'b1;
        drain();
        check_caps(tbl[0]);

        // Back-to-back operands with in_valid held high.
        cap0.delete();
        cap1.delete();
        in_valid = 1'b1;
        in_value = 8'd91;
        for (int t = 0; t < 20 && !in_ready0; t++) @(negedge clk);
        @(posedge clk);
        #1;
        in_value = 8'h80;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_valid_%0d", k), int'(q_valid0), 1);
            chk($sformatf("b2b_in_ready_%0d", k), int'(in_ready0), int'(k == 3 || k == 7));
            if (k == 3) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_value = 8'($urandom);
            end
        end
        drain();
        chk("b2b_count", cap0.size(), 8);
        $display("back-to-back 91,-128 lsb-first %p", cap0);

        // Reset in the middle of an operand.
        send(8'd91);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_q_valid", int'(q_valid0 | q_valid1), 0);
        chk("midrst_outputs", int'({q_digit0, q_index0, q_last0, q_digit1, q_index1, q_last1}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_still_idle", int'(q_valid0 | q_valid1), 0);
        cap0.delete();
        cap1.delete();
        send(8'd5);
        drain();
        check_caps(tbl[4]);

        // Every operand, random consumer back-pressure and gaps.
        rand_mode = 1'b1;
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(8'(i ^ 8'h5A));
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        q_ready = 1'b1;
        drain();
        chk("sweep_drained", opnd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
